// File: rtl/seq_calculator.sv
// Handshaked W-bit calculator: single-cycle add/sub, W-cycle shift-add multiply
// and W-cycle restoring divide, producing a 2W-bit result plus error flag.
module seq_calculator #(
    parameter int unsigned W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    operand_a,
    input  logic [W-1:0]    operand_b,
    input  logic [6:0]      operator,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  result,
    output logic            err
);

    localparam int unsigned RW = 2 * W;
    localparam int unsigned CW = $clog2(W + 1);

    localparam logic [6:0] OP_ADD = 7'h2B;
    localparam logic [6:0] OP_SUB = 7'h2D;
    localparam logic [6:0] OP_MUL = 7'h2A;
    localparam logic [6:0] OP_DIV = 7'h2F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic          is_mul;
    logic [CW-1:0] cnt;
    logic [RW-1:0] acc;
    logic [RW-1:0] mcand;
    logic [W-1:0]  shreg;      // multiplier (shifts right) or dividend/quotient (shifts left)
    logic [W-1:0]  divisor;
    logic [W-1:0]  rem;

    logic          needs_engine;
    logic          last_iter;
    logic [RW-1:0] mul_acc_nxt;
    logic [W:0]    rem_shift;
    logic          fits;
    logic [W-1:0]  rem_sub;
    logic [W-1:0]  rem_nxt;
    logic [W-1:0]  quo_nxt;

    // Engine step and decode helpers
    always_comb begin
        needs_engine = (operator == OP_MUL) || ((operator == OP_DIV) && (operand_b != '0));
        last_iter    = (cnt == CW'(W - 1));
        mul_acc_nxt  = shreg[0] ? (acc + mcand) : acc;
        rem_shift    = {rem, shreg[W-1]};
        fits         = (rem_shift >= {1'b0, divisor});
        rem_sub      = rem_shift[W-1:0] - divisor;
        rem_nxt      = fits ? rem_sub : rem_shift[W-1:0];
        quo_nxt      = {shreg[W-2:0], fits};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = needs_engine ? BUSY : DONE;
            BUSY:    if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            err       <= 1'b0;
            is_mul    <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            shreg     <= '0;
            divisor   <= '0;
            rem       <= '0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt <= '0;
                        acc <= '0;
                        rem <= '0;
                        case (operator)
                            OP_ADD: begin
                                result <= RW'(operand_a) + RW'(operand_b);
                                err    <= 1'b0;
                            end
                            // 2W-bit wraparound yields the all-ones upper half when a < b
                            OP_SUB: begin
                                result <= RW'(operand_a) - RW'(operand_b);
                                err    <= 1'b0;
                            end
                            OP_MUL: begin
                                is_mul <= 1'b1;
                                mcand  <= RW'(operand_a);
                                shreg  <= operand_b;
                            end
                            OP_DIV: begin
                                if (operand_b == '0) begin
                                    result <= '1;
                                    err    <= 1'b1;
                                end else begin
                                    is_mul  <= 1'b0;
                                    shreg   <= operand_a;
                                    divisor <= operand_b;
                                end
                            end
                            default: begin
                                result <= '0;
                                err    <= 1'b1;
                            end
                        endcase
                    end
                end
                BUSY: begin
                    cnt <= cnt + CW'(1);
                    if (is_mul) begin
                        acc   <= mul_acc_nxt;
                        mcand <= mcand << 1;
                        shreg <= shreg >> 1;
                    end else begin
                        rem   <= rem_nxt;
                        shreg <= quo_nxt;
                    end
                    if (last_iter) begin
                        result <= is_mul ? mul_acc_nxt : {quo_nxt, rem_nxt};
                        err    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_calculator.sv
// Self-checking bench for seq_calculator (W=4): vector table, hand-written
// handshake/reset sequences and randomized ops against an arithmetic model.
module tb_seq_calculator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] operand_a;
    logic [3:0] operand_b;
    logic [6:0] operator;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       err;

    int n_pass  = 0;
    int n_total = 0;

    seq_calculator #(.W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .operator  (operator),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [6:0] op;
        logic [7:0] exp_res;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    endtask

    // Reference: plain arithmetic on the operator's meaning
    function automatic void model(input int a, input int b, input logic [6:0] op,
                                  output logic [7:0] r, output logic e, output int lat);
        lat = 1;
        e   = 1'b0;
        case (op)
            7'h2B: r = 8'(a + b);
            7'h2D: r = 8'((a - b + 256) % 256);
            7'h2A: begin r = 8'(a * b); lat = 5; end
            7'h2F: begin
                if (b == 0) begin r = 8'hFF; e = 1'b1; end
                else begin r = 8'((a / b) * 16 + (a % b)); lat = 5; end
            end
            default: begin r = 8'h00; e = 1'b1; end
        endcase
    endfunction

    // Issue one op with out_ready low, measure edges from accept to out_valid, then drain
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [6:0] op,
                          output logic [7:0] res, output logic e, output int lat);
        @(negedge clk);
        check("in_ready before accept", 32'(in_ready), 32'd1);
        operand_a = a;
        operand_b = b;
        operator  = op;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid  = 1'b0;
        operand_a = 4'($urandom);
        operand_b = 4'($urandom);
        operator  = 7'($urandom);
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = result;
        e   = err;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t       vecs[13];
        logic [7:0] res;
        logic       e;
        int         lat;
        logic [7:0] m_res;
        logic       m_err;
        int         m_lat;
        logic [7:0] ops[4];
        logic       stale;

        vecs[0]  = '{4'd15, 4'd15, 7'h2B, 8'h1E, 1'b0, 1};
        vecs[1]  = '{4'd7,  4'd3,  7'h2D, 8'h04, 1'b0, 1};
        vecs[2]  = '{4'd3,  4'd7,  7'h2D, 8'hFC, 1'b0, 1};
        vecs[3]  = '{4'd0,  4'd15, 7'h2D, 8'hF1, 1'b0, 1};
        vecs[4]  = '{4'd15, 4'd15, 7'h2A, 8'hE1, 1'b0, 5};
        vecs[5]  = '{4'd0,  4'd9,  7'h2A, 8'h00, 1'b0, 5};
        vecs[6]  = '{4'd13, 4'd4,  7'h2F, 8'h31, 1'b0, 5};
        vecs[7]  = '{4'd2,  4'd3,  7'h2F, 8'h02, 1'b0, 5};
        vecs[8]  = '{4'd9,  4'd0,  7'h2F, 8'hFF, 1'b1, 1};
        vecs[9]  = '{4'd7,  4'd3,  7'h78, 8'h00, 1'b1, 1};
        vecs[10] = '{4'd1,  4'd1,  7'h2A, 8'h01, 1'b0, 5};
        vecs[11] = '{4'd15, 4'd1,  7'h2F, 8'hF0, 1'b0, 5};
        vecs[12] = '{4'd5,  4'd5,  7'h2D, 8'h00, 1'b0, 1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        operand_a = '0; operand_b = '0; operator = '0;
        repeat (2) @(negedge clk);
        check("reset state", {28'd0, in_ready, out_valid, err, 1'b0} | 32'(result) << 4,
              {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, res, e, lat);
            check($sformatf("vec%0d result", i), 32'(res), 32'(vecs[i].exp_res));
            check($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
        end

        // Hold out_ready low: result stable, inputs ignored
        @(negedge clk);
        operand_a = 4'd15; operand_b = 4'd15; operator = 7'h2B; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hold out_valid after 1 edge", 32'(out_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            in_valid  = 1'($urandom);
            operand_a = 4'($urandom);
            operand_b = 4'($urandom);
            operator  = (c % 2 == 0) ? 7'h2D : 7'h2A;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("hold cycle %0d", c), {20'd0, out_valid, in_ready, err, 1'b0, result},
                  {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1E});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("after drain", {20'd0, out_valid, in_ready, err, 1'b0, result},
              {20'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1E});

        // Reset in the middle of a multiply
        operand_a = 4'd15; operand_b = 4'd15; operator = 7'h2A; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid-busy in_ready low", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mid-busy reset", {20'd0, out_valid, in_ready, err, 1'b0, result},
              {20'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        rst = 1'b0;
        out_ready = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid || result != 8'h00) stale = 1'b1;
        end
        out_ready = 1'b0;
        check("no stale result after reset", 32'(stale), 32'd0);

        // Randomized ops against the model
        ops[0] = 8'h2B; ops[1] = 8'h2D; ops[2] = 8'h2A; ops[3] = 8'h2F;
        for (int n = 0; n < 150; n++) begin
            logic [3:0] ra, rb;
            logic [6:0] rop;
            int pick;
            ra   = 4'($urandom);
            rb   = 4'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            pick = int'($urandom_range(0, 4));
            rop  = (pick < 4) ? ops[pick][6:0] : 7'($urandom);
            model(int'(ra), int'(rb), rop, m_res, m_err, m_lat);
            run_op(ra, rb, rop, res, e, lat);
            check($sformatf("rand%0d op=%0h a=%0d b=%0d result", n, rop, ra, rb), 32'(res), 32'(m_res));
            check($sformatf("rand%0d err", n), 32'(e), 32'(m_err));
            check($sformatf("rand%0d latency", n), 32'(lat), 32'(m_lat));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
